clock_time_bcd: RTL

Time-of-day core for the digital clock: divides the system clock down to a 1 s tick and keeps hours, minutes and seconds as 24-hour packed BCD. Two debounced push-button levels let the user set the time. Its `num` output drives the 24-bit input of the six-digit dynamic seven-segment driver directly, with seconds-ones in the lowest nibble.

---
 rtl/clock_time_bcd.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clock_time_bcd.sv
`default_nettype none
// ============================================================================
// Module  : clock_time_bcd
// Brief   : 24-hour packed-BCD time-of-day core with 1 s prescaler and
//           two-button (mode / increment) time setting.
// Revision: 1.0  initial release
// ============================================================================
module clock_time_bcd #(
  parameter logic [31:0] TICK_CNT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [23:0] num,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  localparam logic [31:0] C_WRAP = TICK_CNT - 32'd1;

  // Returns {carry, next}; any value at or above the limit wraps to zero.
  function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
    if (d >= lim) return {1'b1, 4'd0};
    else          return {1'b0, d + 4'd1};
  endfunction

  function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] o);
    if ((t > 4'd2) || ((t == 4'd2) && (o >= 4'd3))) return 8'h00;
    else if (o >= 4'd9)                              return {t + 4'd1, 4'd0};
    else                                             return {t, o + 4'd1};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [3:0]  h_tens_q, h_ones_q, m_tens_q, m_ones_q, s_tens_q, s_ones_q;
  logic [3:0]  h_tens_d, h_ones_d, m_tens_d, m_ones_d, s_tens_d, s_ones_d;
  logic        sec_tick_q, sec_tick_d;
  logic        key_mode_q, key_inc_q;

  logic        w_mode_edge;
  logic        w_inc_edge;
  logic        w_wrap;
  logic [4:0]  w_s_ones_inc, w_s_tens_inc, w_m_ones_inc, w_m_tens_inc;
  logic [7:0]  w_hour_inc;

  assign w_mode_edge  = key_mode & ~key_mode_q;
  assign w_inc_edge   = key_inc & ~key_inc_q;
  assign w_wrap       = (presc_q >= C_WRAP);

  assign w_s_ones_inc = digit_inc(s_ones_q, 4'd9);
  assign w_s_tens_inc = digit_inc(s_tens_q, 4'd5);
  assign w_m_ones_inc = digit_inc(m_ones_q, 4'd9);
  assign w_m_tens_inc = digit_inc(m_tens_q, 4'd5);
  assign w_hour_inc   = hour_inc(h_tens_q, h_ones_q);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    h_tens_d   = h_tens_q;
    h_ones_d   = h_ones_q;
    m_tens_d   = m_tens_q;
    m_ones_d   = m_ones_q;
    s_tens_d   = s_tens_q;
    s_ones_d   = s_ones_q;
    sec_tick_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A mode edge pre-empts a coinciding prescaler wrap.
        if (w_mode_edge) begin
          state_d = ST_SET_HOUR;
          presc_d = 32'd0;
        end else if (w_wrap) begin
          presc_d    = 32'd0;
          sec_tick_d = 1'b1;
          s_ones_d   = w_s_ones_inc[3:0];
          if (w_s_ones_inc[4]) begin
            s_tens_d = w_s_tens_inc[3:0];
            if (w_s_tens_inc[4]) begin
              m_ones_d = w_m_ones_inc[3:0];
              if (w_m_ones_inc[4]) begin
                m_tens_d = w_m_tens_inc[3:0];
                if (w_m_tens_inc[4]) begin
                  {h_tens_d, h_ones_d} = w_hour_inc;
                end
              end
            end
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end

      ST_SET_HOUR: begin
        presc_d = 32'd0;
        if (w_mode_edge) begin
          state_d = ST_SET_MIN;
        end else if (w_inc_edge) begin
          {h_tens_d, h_ones_d} = w_hour_inc;
        end
      end

      ST_SET_MIN: begin
        presc_d = 32'd0;
        if (w_mode_edge) begin
          // Seconds restart so the next tick lands a full period after exit.
          state_d  = ST_RUN;
          s_tens_d = 4'd0;
          s_ones_d = 4'd0;
        end else if (w_inc_edge) begin
          m_ones_d = w_m_ones_inc[3:0];
          if (w_m_ones_inc[4]) begin
            m_tens_d = w_m_tens_inc[3:0];
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        presc_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      presc_q    <= 32'd0;
      h_tens_q   <= 4'd0;
      h_ones_q   <= 4'd0;
      m_tens_q   <= 4'd0;
      m_ones_q   <= 4'd0;
      s_tens_q   <= 4'd0;
      s_ones_q   <= 4'd0;
      sec_tick_q <= 1'b0;
      // History starts high so a key already held at release is not an edge.
      key_mode_q <= 1'b1;
      key_inc_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      h_tens_q   <= h_tens_d;
      h_ones_q   <= h_ones_d;
      m_tens_q   <= m_tens_d;
      m_ones_q   <= m_ones_d;
      s_tens_q   <= s_tens_d;
      s_ones_q   <= s_ones_d;
      sec_tick_q <= sec_tick_d;
      key_mode_q <= key_mode;
      key_inc_q  <= key_inc;
    end
  end

  assign num      = {h_tens_q, h_ones_q, m_tens_q, m_ones_q, s_tens_q, s_ones_q};
  assign mode     = state_q;
  assign sec_tick = sec_tick_q;

endmodule
`default_nettype wire
